// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg
//   Shared constants and helpers for mem_responder: where the IO region lives
//   in the address map and which registers it holds.
package mem_resp_pkg;

  // Address bits [17:16] equal to this value select the IO region.
  localparam logic [1:0]  IO_REGION_SEL = 2'b11;
  // UART transmit data register (write pushes a byte into the TX FIFO).
  localparam logic [31:0] IO_UART_ADDR  = 32'h0003_0000;
  // UART status register (read returns the TX FIFO occupancy).
  localparam logic [31:0] IO_STAT_ADDR  = 32'h0003_0004;

  typedef enum logic [1:0] {
    IO_REG_UART,
    IO_REG_STAT,
    IO_REG_NONE
  } io_reg_e;

  function automatic logic is_io_region(input logic [1:0] sel_bits);
    return sel_bits == IO_REGION_SEL;
  endfunction

  // Only the low 18 address bits take part in IO register decoding.
  function automatic io_reg_e io_decode(input logic [17:0] addr);
    if (addr == IO_UART_ADDR[17:0]) begin
      return IO_REG_UART;
    end
    if (addr == IO_STAT_ADDR[17:0]) begin
      return IO_REG_STAT;
    end
    return IO_REG_NONE;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo
//   Byte-wide synchronous FIFO used as the UART transmit queue.
//   Ports:
//     clk_in     - clock, rising edge
//     rst_in     - asynchronous active-low reset (empties the FIFO)
//     push       - push request for push_data
//     push_data  - byte to enqueue
//     pop        - pop request for the head byte (ignored when empty)
//     head       - byte at the head of the queue
//     count      - occupancy, 0..DEPTH
//     full       - count == DEPTH
//     empty      - count == 0
//   DEPTH must be a power of two so the pointers wrap by natural overflow.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_pop_ok;
  logic          w_push_ok;

  // A pop needs something to pop; a push into a full FIFO is still
  // accepted when a pop frees the slot in the same cycle.
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_in) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

endmodule

// File: rtl/mem_responder.sv
// mem_responder
//   Byte-wide memory target: a RAM of 2^ADDR_WIDTH bytes with a fixed
//   one-cycle read latency, optionally with a small IO region holding a UART
//   transmit FIFO.
//   Optional feature macro: MEM_RESPONDER_IO_EN
//     defined   - addresses with mem_a[17:16]==2'b11 form the IO region:
//                 0x30000 write pushes into the TX FIFO, 0x30004 read returns
//                 the FIFO occupancy, everything else reads 0x00.
//     undefined - every address maps to RAM; io_buffer_full, tx_valid and
//                 tx_data are tied to zero.
//   Ports:
//     clk_in         - clock, rising edge
//     rst_in         - asynchronous active-low reset
//     rdy_in         - global ready; when low the memory side stalls
//     mem_a          - byte address
//     mem_wr         - 1 = write, 0 = read
//     mem_dout       - write data from the initiator
//     mem_din        - read data, valid the cycle after the read is sampled
//     io_buffer_full - TX FIFO has at most one free slot left
//     tx_data        - TX FIFO head byte
//     tx_valid       - TX FIFO not empty
//     tx_ready       - UART sink takes the head byte this cycle
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  logic [7:0]            r_ram [2**ADDR_WIDTH];
  logic [7:0]            r_din;
  logic [ADDR_WIDTH-1:0] w_ram_idx;
  logic                  w_ram_we;
  logic [7:0]            w_rd_data;
  logic                  w_unused;

  assign w_ram_idx = mem_a[ADDR_WIDTH-1:0];

`ifdef MEM_RESPONDER_IO_EN
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          w_io_sel;
  logic          w_push;
  logic [CW-1:0] w_count;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [7:0]    w_io_rd_data;

  assign w_io_sel = is_io_region(mem_a[17:16]);
  assign w_push   = rdy_in && mem_wr && w_io_sel
                    && (io_decode(mem_a[17:0]) == IO_REG_UART);

  // The sink drains the FIFO on its own handshake, even while the memory
  // side is stalled by rdy_in.
  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .push     (w_push),
    .push_data(mem_dout),
    .pop      (tx_ready),
    .head     (tx_data),
    .count    (w_count),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty)
  );

  // IO read mux: only the status register returns something non-zero.
  always_comb begin
    w_io_rd_data = 8'h00;
    if (io_decode(mem_a[17:0]) == IO_REG_STAT) begin
      w_io_rd_data = 8'(w_count);
    end
  end

  assign w_ram_we  = mem_wr && !w_io_sel;
  assign w_rd_data = w_io_sel ? w_io_rd_data : r_ram[w_ram_idx];

  assign tx_valid = !w_fifo_empty;
  // Raised one entry early: the initiator sees this flag a cycle late and
  // may still issue one more push.
  assign io_buffer_full = (w_count >= CW'(FIFO_DEPTH - 1));

  assign w_unused = ^{mem_a, w_fifo_full};
`else
  assign w_ram_we       = mem_wr;
  assign w_rd_data      = r_ram[w_ram_idx];
  assign tx_valid       = 1'b0;
  assign tx_data        = 8'h00;
  assign io_buffer_full = 1'b0;

  assign w_unused = ^{mem_a, tx_ready};
`endif

  // RAM array has no reset so its contents survive rst_in.
  always_ff @(posedge clk_in) begin
    if (rdy_in && w_ram_we) begin
      r_ram[w_ram_idx] <= mem_dout;
    end
  end

  // Read data register; writes and stalls leave the last response in place.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_din <= 8'h00;
    end else if (rdy_in && !mem_wr) begin
      r_din <= w_rd_data;
    end
  end

  assign mem_din = r_din;

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Directed bench for mem_responder. Read responses and UART bytes are
//   predicted when the stimulus is issued and queued; monitors compare them
//   against mem_din (one cycle after each sampled read) and tx_data (on each
//   tx_valid/tx_ready handshake). Builds with or without MEM_RESPONDER_IO_EN.
module tb_mem_responder;

  localparam logic [31:0] UART    = 32'h0003_0000;
  localparam logic [31:0] STAT    = 32'h0003_0004;
  localparam logic [31:0] SCRATCH = 32'h0000_FFF0;

  logic        clk_in   = 1'b0;
  logic        rst_in   = 1'b0;
  logic        rdy_in   = 1'b1;
  logic [31:0] mem_a    = SCRATCH;
  logic        mem_wr   = 1'b1;
  logic [7:0]  mem_dout = 8'h00;
  logic        tx_ready = 1'b0;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] rdExp [$];
  string      rdName [$];
  logic [7:0] txExp [$];
  logic       rdFire;
  logic [7:0] burst [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk_in = ~clk_in;

  mem_responder #(
    .ADDR_WIDTH(17),
    .FIFO_DEPTH(8)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .mem_a         (mem_a),
    .mem_wr        (mem_wr),
    .mem_dout      (mem_dout),
    .mem_din       (mem_din),
    .io_buffer_full(io_buffer_full),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready)
  );

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
    end
  endtask

  // Drive one bus cycle; it is sampled on the next rising edge.
  task automatic applyStimulus(input logic rdy, input logic wr,
                               input logic [31:0] addr, input logic [7:0] data);
    @(posedge clk_in);
    #1;
    rdy_in   = rdy;
    mem_wr   = wr;
    mem_a    = addr;
    mem_dout = data;
  endtask

  task automatic issueRead(input logic [31:0] addr, input logic [7:0] expected,
                           input string name);
    applyStimulus(1'b1, 1'b0, addr, 8'h00);
    rdExp.push_back(expected);
    rdName.push_back(name);
  endtask

  // A read sampled on an edge must show up on mem_din before the next edge.
  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) rdFire <= 1'b0;
    else         rdFire <= rdy_in && !mem_wr;
  end

  always @(negedge clk_in) begin
    if (rdFire) begin
      if (rdExp.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected read: got 0x%02h, expected none", mem_din);
      end else begin
        checkOutput(rdName.pop_front(), mem_din, rdExp.pop_front());
      end
    end
    if (tx_valid && tx_ready) begin
      if (txExp.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected tx byte: got 0x%02h, expected none", tx_data);
      end else begin
        checkOutput("tx_data order", tx_data, txExp.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3;
    checkOutput("reset mem_din", mem_din, 8'h00);
    checkOutput("reset tx_valid", 8'(tx_valid), 8'h00);
    checkOutput("reset io_buffer_full", 8'(io_buffer_full), 8'h00);
`ifndef MEM_RESPONDER_IO_EN
    checkOutput("reset tx_data", tx_data, 8'h00);
`endif
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;

    // Single write then read-back with one-cycle latency.
    applyStimulus(1'b1, 1'b1, 32'h10, 8'hA5);
    issueRead(32'h10, 8'hA5, "read-after-write 0x10");
    issueRead(32'hFFFC_0010, 8'hA5, "upper address bits ignored");

    // Burst of writes then back-to-back reads.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 32'h100 + 32'(i), burst[i]);
    issueRead(32'h100, 8'h11, "burst read 0x100");
    issueRead(32'h101, 8'h22, "burst read 0x101");
    issueRead(32'h102, 8'h33, "burst read 0x102");
    issueRead(32'h103, 8'h44, "burst read 0x103");

    // Stall: writes and reads with rdy_in low change nothing.
    applyStimulus(1'b1, 1'b1, 32'h20, 8'h5C);
    issueRead(32'h10, 8'hA5, "read before stall");
    applyStimulus(1'b0, 1'b1, 32'h20, 8'h77);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_in);
      #1;
      checkOutput("mem_din held during stalled write", mem_din, 8'hA5);
    end
    applyStimulus(1'b0, 1'b0, 32'h100, 8'h00);
    @(posedge clk_in);
    #1;
    checkOutput("mem_din held during stalled read", mem_din, 8'hA5);
    issueRead(32'h20, 8'h5C, "stalled write did not land");

    applyStimulus(1'b1, 1'b1, 32'h40, 8'h55);

`ifdef MEM_RESPONDER_IO_EN
    issueRead(UART, 8'h00, "IO read 0x30000");
    applyStimulus(1'b1, 1'b1, STAT, 8'hEE);
    issueRead(STAT, 8'h00, "status empty, write to 0x30004 ignored");
    issueRead(32'h30008, 8'h00, "IO read other address");

    // Fill the FIFO with the sink blocked; the 9th push is dropped.
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(1'b1, 1'b1, UART, 8'(k));
      if (k <= 8) txExp.push_back(8'(k));
      if (k == 7) checkOutput("io_buffer_full after 6 pushes", 8'(io_buffer_full), 8'h00);
      if (k == 8) checkOutput("io_buffer_full after 7 pushes", 8'(io_buffer_full), 8'h01);
    end
    issueRead(STAT, 8'h08, "status full after 9th push");

    // Push and pop together while full.
    applyStimulus(1'b1, 1'b1, UART, 8'hAA);
    tx_ready = 1'b1;
    txExp.push_back(8'hAA);
    issueRead(STAT, 8'h08, "status after push+pop at full");
    applyStimulus(1'b1, 1'b1, SCRATCH, 8'h00);
    for (int c = 0; c < 20 && (tx_valid || txExp.size() != 0); c++) begin
      @(posedge clk_in);
      #1;
    end
    checkOutput("tx_valid after drain", 8'(tx_valid), 8'h00);
    checkOutput("tx bytes outstanding", 8'(txExp.size()), 8'h00);
    checkOutput("io_buffer_full after drain", 8'(io_buffer_full), 8'h00);

    // Queue four bytes, drain one, reset with three still queued.
    tx_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 1'b1, UART, 8'hC1 + 8'(k));
      txExp.push_back(8'hC1 + 8'(k));
    end
    applyStimulus(1'b1, 1'b1, SCRATCH, 8'h00);
    tx_ready = 1'b1;
    @(posedge clk_in);
    #2;
`else
    applyStimulus(1'b1, 1'b1, UART, 8'h3C);
    issueRead(UART, 8'h3C, "no-IO 0x30000 is RAM");
    issueRead(32'h10000, 8'h3C, "no-IO alias 0x10000");
    applyStimulus(1'b1, 1'b1, 32'h10004, 8'h9E);
    issueRead(STAT, 8'h9E, "no-IO 0x30004 is RAM");
    applyStimulus(1'b1, 1'b1, SCRATCH, 8'h00);
    checkOutput("no-IO tx_valid", 8'(tx_valid), 8'h00);
    checkOutput("no-IO tx_data", tx_data, 8'h00);
    checkOutput("no-IO io_buffer_full", 8'(io_buffer_full), 8'h00);
    @(posedge clk_in);
    #2;
`endif

    rst_in = 1'b0;
    txExp.delete();
    #1;
    checkOutput("mid-run reset tx_valid", 8'(tx_valid), 8'h00);
    checkOutput("mid-run reset io_buffer_full", 8'(io_buffer_full), 8'h00);
    checkOutput("mid-run reset mem_din", mem_din, 8'h00);
    tx_ready = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    checkOutput("tx_valid after reset release", 8'(tx_valid), 8'h00);

    issueRead(32'h40, 8'h55, "RAM 0x40 survives reset");
    issueRead(32'h10, 8'hA5, "RAM 0x10 survives reset");
`ifdef MEM_RESPONDER_IO_EN
    issueRead(STAT, 8'h00, "status after reset");
`endif
    applyStimulus(1'b1, 1'b1, SCRATCH, 8'h00);
    repeat (2) @(posedge clk_in);
    #1;
    checkOutput("read responses outstanding", 8'(rdExp.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 17, meaning RAM byte-address bits (RAM size 2^ADDR_WIDTH bytes).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning the UART TX FIFO depth in bytes (power of two, at least 4).
REQ-003 The block SHALL have the port clk_in, input, 1 bit: the single clock, with all state on the rising edge.
REQ-004 The block SHALL have the port rst_in, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have the port rdy_in, input, 1 bit: global ready; when low, the memory side stalls.
REQ-006 The block SHALL have the port mem_a, input, 32 bits: the byte address driven by the initiator.
REQ-007 The block SHALL have the port mem_wr, input, 1 bit: 1 means write, 0 means read.
REQ-008 The block SHALL have the port mem_dout, input, 8 bits: write data from the initiator.
REQ-009 The block SHALL have the port mem_din, output, 8 bits: read data returned to the initiator.
REQ-010 The block SHALL have the port io_buffer_full, output, 1 bit: the UART FIFO is near full.
REQ-011 The block SHALL have the ports tx_data (output, 8 bits) and tx_valid (output, 1 bit): the FIFO head byte and its valid flag.
REQ-012 The block SHALL have the port tx_ready, input, 1 bit: the UART sink accepts the head byte.

Function
REQ-013 The block SHALL decode addresses as follows.
- IO region when mem_a[17:16]==2'b11.
- RAM otherwise, at index mem_a[ADDR_WIDTH-1:0]; upper bits ignored.
REQ-014 The block SHALL perform a RAM read sampled at edge N (mem_wr=0, rdy_in=1) and present the byte on mem_din after edge N, stable for all of cycle N+1; read latency is fixed at 1 cycle.
REQ-015 The block SHALL write mem_dout to RAM on edge N when mem_wr=1 and rdy_in=1; a read of the same address issued at N+1 returns the new byte.
REQ-016 The block SHALL, on a write to IO address 0x30000, push mem_dout into the FIFO.
- The push is accepted if the FIFO is not full, or if it is full with a pop in the same cycle.
- Otherwise the byte is silently dropped.
REQ-017 The block SHALL return the following on IO reads.
- 0x30000 returns 0x00.
- 0x30004 returns the FIFO occupancy, zero-extended.
- Any other IO address returns 0x00.
- IO writes other than 0x30000 are ignored.
REQ-018 The block SHALL hold mem_din and write nothing to RAM or FIFO while rdy_in=0.
REQ-019 The block SHALL drive tx_valid = (count != 0) and tx_data = the FIFO head; a pop occurs on any edge with tx_valid && tx_ready, independent of rdy_in.
REQ-020 The block SHALL handle a simultaneous push and pop as follows: both happen and count is unchanged, including when count==FIFO_DEPTH.
REQ-021 The block SHALL wrap the read and write pointers modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH and SHALL never underflow or overflow.
REQ-022 The block SHALL assert io_buffer_full combinationally when count >= FIFO_DEPTH-1, giving one slot of slack for the initiator's one-cycle-late view.

Reset
REQ-023 The block SHALL, while rst_in is low, asynchronously drive mem_din=0x00, FIFO empty (pointers 0, count 0), tx_valid=0, and io_buffer_full=0.
REQ-024 The block SHALL NOT reset RAM contents; a reset mid-operation SHALL discard all queued FIFO bytes and abort any pending read response.

Configuration
REQ-025 The block SHALL, with macro MEM_RESPONDER_IO_EN defined, implement the IO region and FIFO as specified in REQ-016 to REQ-022.
REQ-026 The block SHALL, without MEM_RESPONDER_IO_EN, have no FIFO logic.
- All addresses map to RAM.
- io_buffer_full is tied 0.
- tx_valid is tied 0.
- tx_data is tied 0x00.
- Port list is unchanged.

Structure
REQ-027 The block SHALL take the constants IO_REGION_SEL (2'b11), IO_UART_ADDR (0x30000), and IO_STAT_ADDR (0x30004) from the shared package mem_resp_pkg.
REQ-028 The block SHALL implement the FIFO as the sub-module byte_fifo (parameter DEPTH; ports push, push_data, pop, head, count, full, empty); the RAM SHALL be an inferred array in the top level.

Verification
REQ-029 The bench SHALL write 0xA5 to 0x00010, then read 0x00010 -> mem_din==0xA5 exactly one cycle after the read address.
REQ-030 The bench SHALL write 4 bytes to 0x100..0x103 (0x11,0x22,0x33,0x44), then read them in consecutive cycles -> mem_din yields 0x11,0x22,0x33,0x44 on consecutive cycles.
REQ-031 The bench SHALL push 8 bytes to 0x30000 with tx_ready=0 -> io_buffer_full rises after the 7th push; a 9th push is dropped; a read of 0x30004 returns 8.
REQ-032 The bench SHALL raise tx_ready with FIFO full and push simultaneously -> count stays 8, tx_data advances in order, and the pushed byte is the last to drain.
REQ-033 The bench SHALL hold rdy_in=0 while driving a write 0x77 to 0x20 -> RAM is unchanged and mem_din is held; after rdy_in=1, a read of 0x20 returns the old value.
REQ-034 The bench SHALL assert rst_in low mid-drain with 3 bytes queued -> tx_valid=0 and count=0 immediately (asynchronous); RAM data written before the reset reads back intact.
